// File: rtl/pkt_fmt_pkg.sv
// rtl/pkt_fmt_pkg.sv - packet-word format constants shared by the receive-gate slice
//
// Purpose: word-type codes, field positions and width of the 134-bit packet word,
//          plus the gate FSM state type.
// Ports:   none (package).
package pkt_fmt_pkg;

   localparam int PKT_W   = 134;

   localparam int TYPE_HI = 133;
   localparam int TYPE_LO = 132;
   localparam int INV_HI  = 131;
   localparam int INV_LO  = 128;

   localparam logic [1:0] HEAD = 2'b01;
   localparam logic [1:0] BODY = 2'b11;
   localparam logic [1:0] TAIL = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      DROP = 2'd2
   } gate_state_e;

   function automatic logic [1:0] word_type(input logic [PKT_W-1:0] word);
      return word[TYPE_HI:TYPE_LO];
   endfunction

endpackage

// File: rtl/rx_pkt_gate_sync_fifo.sv
// rtl/rx_pkt_gate_sync_fifo.sv - single-clock FIFO with registered and show-ahead read ports
//
// Purpose: circular buffer with binary pointers one bit wider than the address,
//          the extra bit distinguishing full from empty.
// Ports:   clk, reset      clock and synchronous active-high reset
//          wr_en, wr_data  write strobe and data; dropped when full
//          rd_en           pop strobe; ignored when empty
//          rd_data         registered copy of the word popped on the previous cycle
//          head_data       combinational view of the oldest stored word
//          full, empty     occupancy flags
//          used, used_next current occupancy and occupancy after this cycle's accesses
//          overflow        write attempted while full (single-cycle indication)
module sync_fifo #(
   parameter int W  = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic [W-1:0]  head_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   used,
   output logic [AW:0]   used_next,
   output logic          overflow
);

   localparam int DEPTH = 1 << AW;

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         wr_ok;
   logic         rd_ok;

   // Pointer difference wraps correctly because both pointers wrap modulo 2^(AW+1).
   assign used      = wr_ptr - rd_ptr;
   assign full      = used[AW];
   assign empty     = (wr_ptr == rd_ptr);
   assign wr_ok     = wr_en & ~full;
   assign rd_ok     = rd_en & ~empty;
   assign overflow  = wr_en & full;
   assign used_next = used + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
   assign head_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rd_data <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr[AW-1:0]];
         end
      end
   end

endmodule

// File: rtl/rx_pkt_gate.sv
// rtl/rx_pkt_gate.sv - buffers whole receive packets and forwards only flagged-good ones
//
// Purpose: packet words and per-packet keep flags are queued separately; a queued
//          flag means its packet is fully buffered, so the gate then streams the
//          packet out (flag 1) or discards it (flag 0).
// Ports:   clk, reset                       clock, synchronous active-high reset
//          in_pkt_wrreq, in_pkt             incoming packet words
//          in_pkt_almostfull                registered back-pressure to upstream
//          in_valid_wrreq, in_valid         per-packet keep flag
//          out_pkt_wrreq, out_pkt           forwarded words
//          out_pkt_almostfull               downstream back-pressure (checked per packet)
//          out_valid_wrreq, out_valid       downstream flag, with the tail word
//          pkt_forward_add, pkt_drop_add    per-packet statistics pulses
//          overflow_err                     sticky buffer-overflow indication
module rx_pkt_gate
   import pkt_fmt_pkg::*;
#(
   parameter int DATA_AW      = 8,
   parameter int FLAG_AW      = 6,
   parameter int AFULL_MARGIN = 100
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_pkt_wrreq,
   input  logic [PKT_W-1:0] in_pkt,
   output logic             in_pkt_almostfull,
   input  logic             in_valid_wrreq,
   input  logic             in_valid,
   output logic             out_pkt_wrreq,
   output logic [PKT_W-1:0] out_pkt,
   input  logic             out_pkt_almostfull,
   output logic             out_valid_wrreq,
   output logic             out_valid,
   output logic             pkt_forward_add,
   output logic             pkt_drop_add,
   output logic             overflow_err
);

   localparam int DDEPTH = 1 << DATA_AW;
   // free < margin  <=>  used > depth - margin
   localparam logic [DATA_AW:0] D_AF_LIMIT = (DATA_AW+1)'(DDEPTH - AFULL_MARGIN);
   localparam logic [FLAG_AW:0] F_AF_LIMIT = (FLAG_AW+1)'((1 << FLAG_AW) - 2);

   gate_state_e state;
   gate_state_e next_state;

   logic [PKT_W-1:0] data_rd;
   logic [PKT_W-1:0] data_head;
   logic             data_full;
   logic             data_empty;
   logic [DATA_AW:0] data_used;
   logic [DATA_AW:0] data_used_next;
   logic             data_ovf;
   logic             data_pop;

   logic [0:0]       flag_rd;
   logic [0:0]       flag_head;
   logic             flag_full;
   logic             flag_empty;
   logic [FLAG_AW:0] flag_used;
   logic [FLAG_AW:0] flag_used_next;
   logic             flag_ovf;
   logic             flag_pop;

   logic             pop_tail;
   logic             almostfull_next;
   logic             unused_bits;

   sync_fifo #(.W(PKT_W), .AW(DATA_AW)) u_data_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (in_pkt_wrreq),
      .wr_data   (in_pkt),
      .rd_en     (data_pop),
      .rd_data   (data_rd),
      .head_data (data_head),
      .full      (data_full),
      .empty     (data_empty),
      .used      (data_used),
      .used_next (data_used_next),
      .overflow  (data_ovf)
   );

   sync_fifo #(.W(1), .AW(FLAG_AW)) u_flag_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (in_valid_wrreq),
      .wr_data   (in_valid),
      .rd_en     (flag_pop),
      .rd_data   (flag_rd),
      .head_data (flag_head),
      .full      (flag_full),
      .empty     (flag_empty),
      .used      (flag_used),
      .used_next (flag_used_next),
      .overflow  (flag_ovf)
   );

   // The decision reads the show-ahead side; the registered read side of the flag
   // buffer and the payload bits of the head word are not needed here.
   assign unused_bits = ^{data_head[INV_HI:0], data_full, data_used,
                          flag_rd, flag_full, flag_used};

   // The word type is judged on the word leaving the buffer this cycle, so a
   // stray head word mid-packet is simply carried along as data.
   assign pop_tail = data_pop && (word_type(data_head) == TAIL);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      flag_pop   = 1'b0;
      data_pop   = 1'b0;
      case (state)
         IDLE: begin
            if (!flag_empty) begin
               if (flag_head[0]) begin
                  if (!out_pkt_almostfull) begin
                     flag_pop   = 1'b1;
                     next_state = FWD;
                  end
               end else begin
                  // Discards never wait on downstream back-pressure.
                  flag_pop   = 1'b1;
                  next_state = DROP;
               end
            end
         end
         FWD, DROP: begin
            if (!data_empty) begin
               data_pop = 1'b1;
               if (word_type(data_head) == TAIL) begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Evaluated on next-cycle occupancy so the registered flag lines up with the
   // cycle right after the write that crosses the threshold.
   assign almostfull_next = (data_used_next > D_AF_LIMIT) ||
                            (flag_used_next >= F_AF_LIMIT);

   assign out_pkt = data_rd;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_pkt_wrreq     <= 1'b0;
         out_valid_wrreq   <= 1'b0;
         out_valid         <= 1'b0;
         pkt_forward_add   <= 1'b0;
         pkt_drop_add      <= 1'b0;
         in_pkt_almostfull <= 1'b0;
         overflow_err      <= 1'b0;
      end else begin
         out_pkt_wrreq     <= data_pop && (state == FWD);
         out_valid_wrreq   <= pop_tail && (state == FWD);
         out_valid         <= pop_tail && (state == FWD);
         pkt_forward_add   <= pop_tail && (state == FWD);
         pkt_drop_add      <= pop_tail && (state == DROP);
         in_pkt_almostfull <= almostfull_next;
         overflow_err      <= overflow_err | data_ovf | flag_ovf;
      end
   end

endmodule

// File: tb/tb_rx_pkt_gate.sv
// tb/tb_rx_pkt_gate.sv - self-checking bench for rx_pkt_gate
module tb_rx_pkt_gate;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_pkt_wrreq;
   logic [133:0] in_pkt;
   logic         in_pkt_almostfull;
   logic         in_valid_wrreq;
   logic         in_valid;
   logic         out_pkt_wrreq;
   logic [133:0] out_pkt;
   logic         out_pkt_almostfull;
   logic         out_valid_wrreq;
   logic         out_valid;
   logic         pkt_forward_add;
   logic         pkt_drop_add;
   logic         overflow_err;

   always #5 clk = ~clk;

   rx_pkt_gate dut (
      .clk                (clk),
      .reset              (reset),
      .in_pkt_wrreq       (in_pkt_wrreq),
      .in_pkt             (in_pkt),
      .in_pkt_almostfull  (in_pkt_almostfull),
      .in_valid_wrreq     (in_valid_wrreq),
      .in_valid           (in_valid),
      .out_pkt_wrreq      (out_pkt_wrreq),
      .out_pkt            (out_pkt),
      .out_pkt_almostfull (out_pkt_almostfull),
      .out_valid_wrreq    (out_valid_wrreq),
      .out_valid          (out_valid),
      .pkt_forward_add    (pkt_forward_add),
      .pkt_drop_add       (pkt_drop_add),
      .overflow_err       (overflow_err)
   );

   typedef struct {
      logic         rst;
      logic         pw;
      logic [133:0] pkt;
      logic         vw;
      logic         v;
      logic         oaf;
      logic         e_opw;
      logic [133:0] e_opkt;
      logic         e_ovw;
      logic         e_fwd;
      logic         e_drp;
      logic         e_iaf;
   } vec_t;

   vec_t         tbl[$];
   logic [133:0] wd[4];
   logic [133:0] xd[4];
   logic [133:0] mon_q[$];
   logic [133:0] exp_q[$];
   int           n_vec = 0;
   int           n_err = 0;
   int           fwd_cnt = 0;
   int           drp_cnt = 0;
   int           ovw_cnt = 0;

   function automatic logic [133:0] mkw(input logic [1:0] t, input logic [3:0] inv,
                                        input logic [127:0] d);
      return {t, inv, d};
   endfunction

   function automatic vec_t mkv(input logic rst, input logic pw, input logic [133:0] pkt,
                                input logic vw, input logic v, input logic oaf,
                                input logic e_opw, input logic [133:0] e_opkt,
                                input logic e_ovw, input logic e_fwd,
                                input logic e_drp, input logic e_iaf);
      vec_t r;
      r.rst = rst; r.pw = pw; r.pkt = pkt; r.vw = vw; r.v = v; r.oaf = oaf;
      r.e_opw = e_opw; r.e_opkt = e_opkt; r.e_ovw = e_ovw;
      r.e_fwd = e_fwd; r.e_drp = e_drp; r.e_iaf = e_iaf;
      return r;
   endfunction

   task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (out_pkt_wrreq === 1'b1) mon_q.push_back(out_pkt);
      if (pkt_forward_add === 1'b1) fwd_cnt++;
      if (pkt_drop_add === 1'b1) drp_cnt++;
      if (out_valid_wrreq === 1'b1) begin
         ovw_cnt++;
         chk("out_valid_with_strobe", {133'd0, out_valid}, 134'd1);
      end
   endtask

   task automatic drive(input logic pw, input logic [133:0] pkt, input logic vw, input logic v);
      in_pkt_wrreq   = pw;
      in_pkt         = pkt;
      in_valid_wrreq = vw;
      in_valid       = v;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
      mon_q.delete();
      fwd_cnt = 0;
      drp_cnt = 0;
      ovw_cnt = 0;
   endtask

   task automatic clear_mon();
      mon_q.delete();
      fwd_cnt = 0;
      drp_cnt = 0;
      ovw_cnt = 0;
   endtask

   initial begin
      reset = 1'b1;
      out_pkt_almostfull = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);

      wd[0] = mkw(2'b01, 4'd0, 128'h0000_0000_0000_0000_0000_0000_CAFE_0000);
      wd[1] = mkw(2'b11, 4'd0, 128'h1111_2222_3333_4444_5555_6666_CAFE_0001);
      wd[2] = mkw(2'b11, 4'd0, 128'h7777_8888_9999_AAAA_BBBB_CCCC_CAFE_0002);
      wd[3] = mkw(2'b10, 4'd3, 128'hDDDD_EEEE_FFFF_0000_1234_5678_CAFE_0003);
      xd[0] = mkw(2'b01, 4'd0, 128'h5A5A_0000);
      xd[1] = mkw(2'b11, 4'd0, 128'h5A5A_0001);
      xd[2] = mkw(2'b11, 4'd0, 128'h5A5A_0002);
      xd[3] = mkw(2'b10, 4'd7, 128'h5A5A_0003);

      // Kept 4-word packet: flag with the tail, 3-cycle latency to first output.
      tbl.push_back(mkv(1, 0, '0,    0, 0, 0,  0, '0,    0, 0, 0, 0));
      tbl.push_back(mkv(0, 1, wd[0], 0, 0, 0,  0, '0,    0, 0, 0, 0));
      tbl.push_back(mkv(0, 1, wd[1], 0, 0, 0,  0, '0,    0, 0, 0, 0));
      tbl.push_back(mkv(0, 1, wd[2], 0, 0, 0,  0, '0,    0, 0, 0, 0));
      tbl.push_back(mkv(0, 1, wd[3], 1, 1, 0,  0, '0,    0, 0, 0, 0));
      tbl.push_back(mkv(0, 0, '0,    0, 0, 0,  0, '0,    0, 0, 0, 0));
      tbl.push_back(mkv(0, 0, '0,    0, 0, 0,  1, wd[0], 0, 0, 0, 0));
      tbl.push_back(mkv(0, 0, '0,    0, 0, 0,  1, wd[1], 0, 0, 0, 0));
      tbl.push_back(mkv(0, 0, '0,    0, 0, 0,  1, wd[2], 0, 0, 0, 0));
      tbl.push_back(mkv(0, 0, '0,    0, 0, 0,  1, wd[3], 1, 1, 0, 0));
      tbl.push_back(mkv(0, 0, '0,    0, 0, 0,  0, '0,    0, 0, 0, 0));
      // Same packet dropped: nothing downstream, one drop pulse after the tail pop.
      tbl.push_back(mkv(0, 1, wd[0], 0, 0, 0,  0, '0,    0, 0, 0, 0));
      tbl.push_back(mkv(0, 1, wd[1], 0, 0, 0,  0, '0,    0, 0, 0, 0));
      tbl.push_back(mkv(0, 1, wd[2], 0, 0, 0,  0, '0,    0, 0, 0, 0));
      tbl.push_back(mkv(0, 1, wd[3], 1, 0, 0,  0, '0,    0, 0, 0, 0));
      tbl.push_back(mkv(0, 0, '0,    0, 0, 0,  0, '0,    0, 0, 0, 0));
      tbl.push_back(mkv(0, 0, '0,    0, 0, 0,  0, '0,    0, 0, 0, 0));
      tbl.push_back(mkv(0, 0, '0,    0, 0, 0,  0, '0,    0, 0, 0, 0));
      tbl.push_back(mkv(0, 0, '0,    0, 0, 0,  0, '0,    0, 0, 0, 0));
      tbl.push_back(mkv(0, 0, '0,    0, 0, 1,  0, '0,    0, 0, 1, 0));
      tbl.push_back(mkv(0, 0, '0,    0, 0, 0,  0, '0,    0, 0, 0, 0));

      foreach (tbl[i]) begin
         reset = tbl[i].rst;
         out_pkt_almostfull = tbl[i].oaf;
         drive(tbl[i].pw, tbl[i].pkt, tbl[i].vw, tbl[i].v);
         tick();
         chk($sformatf("v%0d.out_pkt_wrreq", i), {133'd0, out_pkt_wrreq}, {133'd0, tbl[i].e_opw});
         if (tbl[i].e_opw) chk($sformatf("v%0d.out_pkt", i), out_pkt, tbl[i].e_opkt);
         chk($sformatf("v%0d.out_valid_wrreq", i), {133'd0, out_valid_wrreq}, {133'd0, tbl[i].e_ovw});
         chk($sformatf("v%0d.out_valid", i), {133'd0, out_valid}, {133'd0, tbl[i].e_ovw});
         chk($sformatf("v%0d.pkt_forward_add", i), {133'd0, pkt_forward_add}, {133'd0, tbl[i].e_fwd});
         chk($sformatf("v%0d.pkt_drop_add", i), {133'd0, pkt_drop_add}, {133'd0, tbl[i].e_drp});
         chk($sformatf("v%0d.in_pkt_almostfull", i), {133'd0, in_pkt_almostfull}, {133'd0, tbl[i].e_iaf});
         chk($sformatf("v%0d.overflow_err", i), {133'd0, overflow_err}, 134'd0);
      end
      reset = 1'b0;
      out_pkt_almostfull = 1'b0;
      chk("drop_data_used", 134'(dut.u_data_fifo.used), 134'd0);

      // Back-to-back keep / drop / keep of 4, 95 and 4 words.
      do_reset();
      exp_q.delete();
      for (int p = 0; p < 3; p++) begin
         int len;
         logic keep;
         len  = (p == 1) ? 95 : 4;
         keep = (p != 1);
         for (int i = 0; i < len; i++) begin
            logic [1:0]   t;
            logic [133:0] w;
            t = (i == 0) ? 2'b01 : ((i == len - 1) ? 2'b10 : 2'b11);
            w = mkw(t, (i == len - 1) ? 4'd2 : 4'd0, {64'(p + 1), 64'(i)});
            drive(1'b1, w, (i == len - 1), keep);
            if (keep) exp_q.push_back(w);
            tick();
         end
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      for (int k = 0; k < 400 && (fwd_cnt + drp_cnt) < 3; k++) tick();
      chk("b2b_packets_done", 134'(fwd_cnt + drp_cnt), 134'd3);
      for (int k = 0; k < 4; k++) tick();
      chk("b2b_word_count", 134'(mon_q.size()), 134'd8);
      for (int i = 0; i < 8 && i < mon_q.size(); i++)
         chk($sformatf("b2b_word%0d", i), mon_q[i], exp_q[i]);
      chk("b2b_forward_pulses", 134'(fwd_cnt), 134'd2);
      chk("b2b_drop_pulses", 134'(drp_cnt), 134'd1);
      chk("b2b_flag_strobes", 134'(ovw_cnt), 134'd2);

      // Downstream back-pressure holds a kept packet in IDLE, not mid-packet.
      do_reset();
      out_pkt_almostfull = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, wd[i], (i == 3), 1'b1);
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) tick();
      chk("bp_held_words", 134'(mon_q.size()), 134'd0);
      out_pkt_almostfull = 1'b0;
      tick();
      chk("bp_idle_pop_no_word", {133'd0, out_pkt_wrreq}, 134'd0);
      tick();
      chk("bp_first_wrreq", {133'd0, out_pkt_wrreq}, 134'd1);
      chk("bp_first_word", out_pkt, wd[0]);
      out_pkt_almostfull = 1'b1;
      for (int i = 1; i < 4; i++) begin
         tick();
         chk($sformatf("bp_mid_wrreq%0d", i), {133'd0, out_pkt_wrreq}, 134'd1);
         chk($sformatf("bp_mid_word%0d", i), out_pkt, wd[i]);
      end
      chk("bp_tail_forward_add", {133'd0, pkt_forward_add}, 134'd1);
      out_pkt_almostfull = 1'b0;

      // Almost-full threshold at 157 words, overflow on the 257th.
      do_reset();
      for (int i = 1; i <= 257; i++) begin
         drive(1'b1, mkw(2'b11, 4'd0, 128'(i)), 1'b0, 1'b0);
         tick();
         if (i == 156) chk("afull_at_156", {133'd0, in_pkt_almostfull}, 134'd0);
         if (i == 157) chk("afull_at_157", {133'd0, in_pkt_almostfull}, 134'd1);
         if (i == 256) chk("ovf_at_256", {133'd0, overflow_err}, 134'd0);
         if (i == 257) chk("ovf_at_257", {133'd0, overflow_err}, 134'd1);
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) tick();
      chk("ovf_sticky", {133'd0, overflow_err}, 134'd1);
      chk("afull_held", {133'd0, in_pkt_almostfull}, 134'd1);
      do_reset();
      chk("ovf_cleared", {133'd0, overflow_err}, 134'd0);
      chk("afull_cleared", {133'd0, in_pkt_almostfull}, 134'd0);

      // Reset in the middle of forwarding, then a fresh packet.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, xd[i], (i == 3), 1'b1);
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      for (int k = 0; k < 10 && out_pkt_wrreq !== 1'b1; k++) tick();
      chk("rst_mid_fwd_started", {133'd0, out_pkt_wrreq}, 134'd1);
      reset = 1'b1;
      tick();
      chk("rst_out_pkt_wrreq", {133'd0, out_pkt_wrreq}, 134'd0);
      chk("rst_out_pkt", out_pkt, 134'd0);
      chk("rst_out_valid_wrreq", {133'd0, out_valid_wrreq}, 134'd0);
      chk("rst_forward_add", {133'd0, pkt_forward_add}, 134'd0);
      chk("rst_drop_add", {133'd0, pkt_drop_add}, 134'd0);
      reset = 1'b0;
      clear_mon();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, wd[i], (i == 3), 1'b1);
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      for (int k = 0; k < 30 && fwd_cnt < 1; k++) tick();
      for (int k = 0; k < 5; k++) tick();
      chk("post_rst_forward_add", 134'(fwd_cnt), 134'd1);
      chk("post_rst_word_count", 134'(mon_q.size()), 134'd4);
      for (int i = 0; i < 4 && i < mon_q.size(); i++)
         chk($sformatf("post_rst_word%0d", i), mon_q[i], wd[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rx_pkt_gate.md
Name: rx_pkt_gate

Overview:
- Sits directly downstream of the port receive path.
- Consumes the 134-bit packet-word stream plus the per-packet valid flag that the port emits, and buffers whole packets.
- Forwards only packets whose flag is 1 to the next pipeline stage; packets whose flag is 0 are dropped silently.
- Provides receive-side back-pressure and per-packet forward/drop pulses for the statistics block.

Parameters:
- DATA_AW, 8, log2 depth of the packet-word buffer (256 words).
- FLAG_AW, 6, log2 depth of the valid-flag buffer (64 entries).
- AFULL_MARGIN, 100, free-word threshold for almost-full; must be at least the word count of a max-length frame plus 4.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- in_pkt_wrreq  in  1  write strobe, one word per cycle.
- in_pkt  in  134  [133:132] word type: 01 head, 11 body, 10 tail. [131:128] invalid byte count, meaningful in the tail word only. [127:0] data.
- in_pkt_almostfull  out  1  back-pressure to the upstream port.
- in_valid_wrreq  in  1  flag write strobe; at most one per packet, issued on or after the tail-word cycle.
- in_valid  in  1  1 = keep the packet, 0 = discard it.
- out_pkt_wrreq  out  1  forwarded-word strobe.
- out_pkt  out  134  forwarded word, unmodified.
- out_pkt_almostfull  in  1  downstream back-pressure.
- out_valid_wrreq  out  1  downstream flag strobe.
- out_valid  out  1  always 1 when out_valid_wrreq is asserted.
- pkt_forward_add  out  1  one-cycle pulse per forwarded packet.
- pkt_drop_add  out  1  one-cycle pulse per dropped packet.
- overflow_err  out  1  sticky; set when a write arrives while the relevant buffer is full.

Behaviour:
- Reset values: every output is 0, both buffers are empty, the FSM is in IDLE, overflow_err is cleared. Reset asserted mid-packet abandons all buffered state; the next cycle behaves as a fresh start.
- Buffer writes:
  - A word is written on every in_pkt_wrreq cycle.
  - A flag is written on every in_valid_wrreq cycle.
  - A write to a full buffer is discarded and sets overflow_err.
  - Simultaneous word and flag writes are both accepted.
- in_pkt_almostfull = (free data words < AFULL_MARGIN) OR (used flag entries >= 2^FLAG_AW - 2). It is a registered output, one cycle behind the occupancy change.
- Ordering guarantee: the flag is written no earlier than the packet's tail word. Therefore a non-empty flag buffer means the head packet is entirely present in the data buffer.
- FSM states:
  - IDLE: wait until the flag buffer is non-empty.
    - Head flag = 1: proceed only when out_pkt_almostfull = 0. Pop the flag and go to FWD.
    - Head flag = 0: pop the flag and go to DROP immediately; out_pkt_almostfull is ignored.
  - FWD: pop one word per cycle with no stall; out_pkt_almostfull is not re-sampled mid-packet.
    - The word type is examined as each word is popped; popping the tail (10) returns the FSM to IDLE.
  - DROP: pop one word per cycle with nothing written downstream; popping the tail returns the FSM to IDLE.
- Output timing:
  - Buffer reads are registered, so out_pkt and out_pkt_wrreq appear 1 cycle after the pop.
  - out_valid_wrreq, out_valid and pkt_forward_add are asserted in the same cycle as the tail word on the output.
  - pkt_drop_add pulses in the cycle after the tail is popped in DROP.
- Throughput and latency:
  - IDLE costs 1 cycle between packets.
  - Minimum latency from flag write to first output word is 3 cycles: flag registered, IDLE decision, read register.
- Malformed input: a head word (01) seen where a body or tail is expected is treated as data; no resynchronisation is attempted.
- Flag values: out_valid is constant 1. Downstream sees only good packets.
- Pointers: binary, DATA_AW+1 and FLAG_AW+1 bits wide, with the extra bit used for full/empty detection. They wrap modulo 2^(AW+1). Used count is the pointer difference truncated to AW+1 bits.

Decomposition:
- Shared package pkt_fmt_pkg:
  - Word-type constants HEAD=2'b01, BODY=2'b11, TAIL=2'b10.
  - Field positions TYPE_HI=133, TYPE_LO=132, INV_HI=131, INV_LO=128.
  - Packet-word width constant 134.
- One sub-module, sync_fifo:
  - Parameterised width and address width.
  - Registered read data, plus full/empty/used outputs and the overflow indication.
  - Instantiated twice: 134-bit data buffer and 1-bit flag buffer.

Test Plan:
- Write a 4-word packet (01,11,11,10; tail [131:128]=4'd3), then flag=1 -> out_pkt_wrreq high for 4 consecutive cycles with identical words; out_valid_wrreq=1, out_valid=1 and pkt_forward_add=1 on the 4th word; pkt_drop_add stays 0.
- Same packet with flag=0 -> no out_pkt_wrreq and no out_valid_wrreq; exactly one pkt_drop_add pulse; data buffer used count returns to 0.
- Alternate keep/drop/keep packets of 4, 95 and 4 words back-to-back -> output shows only packets 1 and 3 (8 words); pkt_forward_add pulses twice, pkt_drop_add once.
- Hold out_pkt_almostfull=1 with a kept packet queued -> no output words; release -> first word 1 cycle after the IDLE pop. Raise it again mid-packet -> the packet still completes with no gap.
- Fill to 157 words (free = 99) -> in_pkt_almostfull=1 the cycle after the write that crossed the threshold. Keep writing to 257 words -> overflow_err=1 and stays set until reset.
- Assert reset for 1 cycle in the middle of FWD -> all outputs 0 next cycle; a subsequent fresh 4-word kept packet is forwarded correctly.
